// File: rtl/jtkiwi_pkg.sv
// jtkiwi_pkg: shared region codes, constants and map decode for the Kiwi sound bus
package jtkiwi_pkg;
   typedef enum logic [2:0] {REG_NONE, REG_ROM, REG_BANK, REG_FM, REG_CAB, REG_RAM} region_t;
   localparam logic [15:0] BANK_BASE    = 16'h8000;
   localparam int          PULSE_LEN    = 16;
   localparam logic [7:0]  VEC_BASE_DEF = 8'hF0;
   function automatic region_t decode(input logic [3:0] nib);
      return nib < 4'hA ? REG_ROM : nib == 4'hA ? REG_BANK : nib == 4'hB ? REG_FM :
             nib == 4'hC ? REG_CAB : nib == 4'hF ? REG_NONE : REG_RAM;
   endfunction
endpackage

// File: rtl/jtkiwi_irqctl.sv
// jtkiwi_irqctl: rising-edge IRQ latch, fixed-priority IM2 vector and INT output
module jtkiwi_irqctl
   import jtkiwi_pkg::*;
#(
   parameter int         IRQN     = 2,
   parameter int         IRQ_M1   = 0,
   parameter logic [7:0] VEC_BASE = VEC_BASE_DEF
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [IRQN-1:0] i_src,
   input  logic            i_iorq_n,
   input  logic            i_m1_n,
   output logic            o_ack,
   output logic [7:0]      o_vec,
   output logic            o_int_n
);
   localparam int IW = $clog2(IRQN + 1);
   logic [IRQN-1:0] r_src_l, r_pend, w_clr;
   logic [IW-1:0]   w_idx;
   logic [7:0]      r_vec;
   logic            w_ack_c, w_ack_rise, r_ack_l;
   assign w_ack_c    = ~i_iorq_n & (IRQ_M1 == 0 || !i_m1_n);
   assign w_ack_rise = w_ack_c & ~r_ack_l;
   // index IRQN means nothing pending and also selects the spare vector
   always_comb begin
      w_idx = IW'(IRQN);
      for (int i = IRQN - 1; i >= 0; i--) w_idx = r_pend[i] ? IW'(i) : w_idx;
   end
   assign w_clr = w_ack_rise ? IRQN'(1) << w_idx : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_src_l <= '0;
         r_pend  <= '0;
         r_ack_l <= 1'b0;
         r_vec   <= 8'd0;
      end else begin
         r_src_l <= i_src;
         r_ack_l <= w_ack_c;
         r_pend  <= (r_pend & ~w_clr) | (i_src & ~r_src_l);
         if (w_ack_rise) r_vec <= VEC_BASE + 8'(2 * w_idx);
      end
   assign o_ack   = r_ack_l;
   assign o_vec   = r_vec;
   assign o_int_n = ~|r_pend;
endmodule

// File: rtl/jtkiwi_sndbus.sv
// jtkiwi_sndbus: Kiwi sound Z80 bus decode, bank/MCU latch, device wait and IRQ control
// Define JTKIWI_WDOG_EN to add the LVBL watchdog driving o_wdog_rst.
module jtkiwi_sndbus
   import jtkiwi_pkg::*;
#(
   parameter int         BANKW    = 2,
   parameter int         IRQN     = 2,
   parameter int         IRQ_M1   = 0,
   parameter logic [7:0] VEC_BASE = VEC_BASE_DEF,
   parameter int         WDOG_LIM = 8,
   localparam int        ROMW     = (BANKW > 2) ? 14 + BANKW : 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cen,
   input  logic [15:0]      i_a,
   input  logic             i_mreq_n,
   input  logic             i_rfsh_n,
   input  logic             i_iorq_n,
   input  logic             i_m1_n,
   input  logic             i_rd_n,
   input  logic             i_wr_n,
   input  logic [7:0]       i_cpu_dout,
   output logic [7:0]       o_cpu_din,
   output logic [ROMW-1:0]  o_rom_addr,
   output logic             o_rom_cs,
   input  logic [7:0]       i_rom_data,
   output logic             o_ram_cs,
   input  logic [7:0]       i_ram_dout,
   input  logic             i_shram_busy,
   output logic             o_fm_cs,
   input  logic [7:0]       i_fm_dout,
   output logic             o_cab_cs,
   input  logic [7:0]       i_cab_dout,
   output logic             o_dev_busy,
   output logic [BANKW-1:0] o_bank,
   output logic             o_mcu_rst,
   input  logic [IRQN-1:0]  i_irq_src,
   output logic             o_int_n,
   input  logic             i_lvbl,
   output logic             o_wdog_rst
);
   region_t          w_reg;
   logic             w_mem_acc, w_bank_wr, w_fm_rise, w_ack, w_unused;
   logic [7:0]       w_vec, r_din;
   logic [ROMW-1:0]  w_rom_addr, r_rom_addr;
   logic             r_rom_cs, r_ram_cs, r_fm_cs, r_cab_cs, r_bank_cs;
   logic             r_fm_l, r_fm_arm, r_fm_busy, r_mcu;
   logic [BANKW-1:0] r_bank;
   assign w_reg      = decode(i_a[15:12]);
   assign w_mem_acc  = ~i_mreq_n & i_rfsh_n;
   assign w_bank_wr  = r_bank_cs & ~i_wr_n;
   assign w_fm_rise  = r_fm_cs & ~r_fm_l;
   assign w_rom_addr = i_a[15] ? ROMW'(BANK_BASE) + ROMW'({r_bank, i_a[12:0]}) : ROMW'(i_a[14:0]);
   assign w_unused   = ^{i_rd_n, i_lvbl, i_cpu_dout, WDOG_LIM[0]};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {r_rom_cs, r_ram_cs, r_fm_cs, r_cab_cs, r_bank_cs} <= '0;
         {r_fm_l, r_fm_arm, r_fm_busy, r_mcu} <= '0;
         r_rom_addr <= '0;
         r_bank     <= '0;
         r_din      <= 8'd0;
      end else begin
         r_rom_cs   <= w_mem_acc && w_reg == REG_ROM;
         r_bank_cs  <= w_mem_acc && w_reg == REG_BANK;
         r_fm_cs    <= w_mem_acc && w_reg == REG_FM;
         r_cab_cs   <= w_mem_acc && w_reg == REG_CAB;
         r_ram_cs   <= w_mem_acc && w_reg == REG_RAM;
         r_rom_addr <= w_rom_addr;
         if (w_bank_wr) {r_mcu, r_bank} <= i_cpu_dout[BANKW:0];
         r_din <= r_rom_cs ? i_rom_data : r_ram_cs ? i_ram_dout : r_fm_cs ? i_fm_dout :
                  r_cab_cs ? i_cab_dout : w_ack ? w_vec : 8'd0;
         r_fm_l <= r_fm_cs;
         // a new FM access arms one busy cen period, held until the next cen
         if (i_cen) begin
            r_fm_busy <= r_fm_arm | w_fm_rise;
            r_fm_arm  <= 1'b0;
         end else if (w_fm_rise) r_fm_arm <= 1'b1;
      end
   assign o_rom_cs   = r_rom_cs;
   assign o_ram_cs   = r_ram_cs;
   assign o_fm_cs    = r_fm_cs;
   assign o_cab_cs   = r_cab_cs;
   assign o_rom_addr = r_rom_addr;
   assign o_bank     = r_bank;
   assign o_mcu_rst  = r_mcu;
   assign o_cpu_din  = r_din;
   assign o_dev_busy = (r_ram_cs & i_shram_busy) | r_fm_busy;
   jtkiwi_irqctl #(.IRQN(IRQN), .IRQ_M1(IRQ_M1), .VEC_BASE(VEC_BASE)) u_irq (
      .clk, .rst, .i_src(i_irq_src), .i_iorq_n, .i_m1_n,
      .o_ack(w_ack), .o_vec(w_vec), .o_int_n
   );
`ifdef JTKIWI_WDOG_EN
   logic       r_lvbl_l;
   logic [7:0] r_wcnt;
   logic [4:0] r_wtmr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_lvbl_l <= 1'b0;
         r_wcnt   <= 8'd0;
         r_wtmr   <= 5'd0;
      end else begin
         r_lvbl_l <= i_lvbl;
         r_wtmr   <= r_wtmr != 5'd0 ? r_wtmr - 5'd1 : 5'd0;
         if (w_bank_wr) r_wcnt <= 8'd0;
         else if (r_wcnt == 8'(WDOG_LIM)) begin
            r_wcnt <= 8'd0;
            r_wtmr <= 5'(PULSE_LEN);
         end else if (r_lvbl_l && !i_lvbl) r_wcnt <= r_wcnt + 8'd1;
      end
   assign o_wdog_rst = r_wtmr != 5'd0;
`else
   assign o_wdog_rst = 1'b0;
`endif
endmodule
